// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit and its buffer.
package fetch_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;
    localparam int ENTRY_W     = 2 * XLEN;

    typedef enum logic {
        FETCH,
        DRAIN
    } fetch_state_e;

    function automatic logic [XLEN-1:0] alignPc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(INSTR_BYTES - 1);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: small circular FIFO of {pc, instr} entries with a flush input.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = ENTRY_W,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] pushData,
    input  logic             pop,
    output logic [WIDTH-1:0] headData,
    output logic             notEmpty,
    output logic [PW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wrPtr;
    logic [PW:0]      rdPtr;
    logic             doPush;
    logic             doPop;

    assign count    = wrPtr - rdPtr;
    assign notEmpty = (count != '0);
    assign doPop    = pop && notEmpty;
    assign doPush   = push && ((count != (PW+1)'(DEPTH)) || doPop);

    // Gate the head so no stale entry is ever visible on the outputs.
    assign headData = notEmpty ? mem[rdPtr[PW-1:0]] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
        end else begin
            if (doPush) begin
                mem[wrPtr[PW-1:0]] <= pushData;
                wrPtr              <= wrPtr + 1'b1;
            end
            if (doPop) begin
                rdPtr <= rdPtr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: in-order fetch requests, response buffering, stale-response discard after redirect.
// Optional FETCH_MISALIGN_TRAP_EN adds FetchMisalign and halts fetching after a misaligned redirect.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            ImemReq,
    output logic [XLEN-1:0] ImemAddr,
    input  logic            ImemGnt,
    input  logic            ImemRValid,
    input  logic [XLEN-1:0] ImemRData,
    input  logic            Redirect,
    input  logic [XLEN-1:0] RedirectPC,
    output logic [XLEN-1:0] Instr,
    output logic [XLEN-1:0] InstrPC,
    output logic            InstrValid,
    input  logic            InstrReady
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic            FetchMisalign
`endif
);

    localparam int          CW    = $clog2(BUF_DEPTH) + 1;
    localparam logic [CW:0] LIMIT = (CW+1)'(BUF_DEPTH);

    fetch_state_e      state;
    logic [XLEN-1:0]   respPc;
    logic [CW-1:0]     inFlight;
    logic [CW-1:0]     inFlightNext;
    logic [CW-1:0]     discardCnt;
    logic [CW-1:0]     discardNext;
    logic [CW-1:0]     fifoCount;
    logic [CW-1:0]     countNext;
    logic              fire;
    logic              dropResp;
    logic              push;
    logic              pop;
    logic              haltNext;
    logic              reqNext;
    logic [XLEN-1:0]   target;
    logic [ENTRY_W-1:0] headData;

    assign fire   = ImemReq && ImemGnt;
    assign target = alignPc(RedirectPC);

    // Everything that bounds the next request is evaluated on post-edge occupancy,
    // so a request once raised stays up until it is granted.
    always_comb begin
        dropResp     = ImemRValid && (state == DRAIN);
        push         = ImemRValid && !dropResp && !Redirect;
        pop          = InstrValid && InstrReady && !Redirect;
        inFlightNext = inFlight + CW'(fire) - CW'(ImemRValid);
        countNext    = Redirect ? '0 : fifoCount + CW'(push) - CW'(pop);
        if (Redirect) begin
            discardNext = inFlightNext;
        end else if (dropResp) begin
            discardNext = discardCnt - CW'(1);
        end else begin
            discardNext = discardCnt;
        end
        reqNext = !haltNext && (({1'b0, inFlightNext} + {1'b0, countNext}) < LIMIT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= FETCH;
            ImemReq    <= 1'b0;
            ImemAddr   <= RESET_PC;
            respPc     <= RESET_PC;
            inFlight   <= '0;
            discardCnt <= '0;
        end else begin
            ImemReq    <= reqNext;
            inFlight   <= inFlightNext;
            discardCnt <= discardNext;
            state      <= (discardNext != '0) ? DRAIN : FETCH;
            if (Redirect) begin
                ImemAddr <= target;
                respPc   <= target;
            end else begin
                if (fire) begin
                    ImemAddr <= ImemAddr + XLEN'(INSTR_BYTES);
                end
                if (push) begin
                    respPc <= respPc + XLEN'(INSTR_BYTES);
                end
            end
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic halted;

    assign haltNext = Redirect ? (RedirectPC[1:0] != 2'b00) : halted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted        <= 1'b0;
            FetchMisalign <= 1'b0;
        end else begin
            halted        <= haltNext;
            FetchMisalign <= Redirect && (RedirectPC[1:0] != 2'b00);
        end
    end
`else
    assign haltNext = 1'b0;
`endif

    fetch_fifo #(
        .DEPTH(BUF_DEPTH),
        .WIDTH(ENTRY_W)
    ) buffer (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (Redirect),
        .push     (push),
        .pushData ({respPc, ImemRData}),
        .pop      (pop),
        .headData (headData),
        .notEmpty (InstrValid),
        .count    (fifoCount)
    );

    assign {InstrPC, Instr} = headData;

endmodule
